// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic keep;
    logic clear;
  } stage_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// Multiply/divide occupancy tracker: busy for exactly MD_CYCLES cycles after an issue edge.
module md_tracker
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  output logic busy_o
);

  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(MD_CYCLES - 1);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter keeps running through memory freezes; the unit is not pipelined with the core.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (issue_i) begin
          state_d = MD_BUSY;
          cnt_d   = LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritized keep/clear controls, MD tracking, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_jump_i,
  input  logic             id_md_start_i,
  input  logic             id_md_read_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_busy_i,
  input  logic             cnt_clr_i,
  output logic             pc_keep_o,
  output logic             ifid_keep_o,
  output logic             ifid_clear_o,
  output logic             idex_keep_o,
  output logic             idex_clear_o,
  output logic             exmem_keep_o,
  output logic             exmem_clear_o,
  output logic             memwb_keep_o,
  output logic             memwb_clear_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic        lu, md_struct, md_issue, pc_keep;
  stage_ctrl_t ifid, idex, exmem, memwb;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign lu = ex_memread_i && (ex_rt_i != REG_ZERO) &&
              ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  assign md_struct = md_busy_o && (id_md_start_i || id_md_read_i);

  // A squashed (branch) or frozen (mem) ID instruction must not start the MD unit.
  assign md_issue = id_md_start_i && !mem_busy_i && !ex_branch_taken_i && !lu && !md_struct;

  md_tracker #(.MD_CYCLES(MD_CYCLES)) u_md (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .issue_i (md_issue),
    .busy_o  (md_busy_o)
  );

  always_comb begin
    pc_keep = 1'b0;
    ifid    = '0;
    idex    = '0;
    exmem   = '0;
    memwb   = '0;
    if (!rst_i) begin
      pc_keep = 1'b0;
    end else if (mem_busy_i) begin
      pc_keep     = 1'b1;
      ifid.keep   = 1'b1;
      idex.keep   = 1'b1;
      exmem.keep  = 1'b1;
      memwb.clear = 1'b1;
    end else if (ex_branch_taken_i) begin
      ifid.clear  = 1'b1;
      idex.clear  = 1'b1;
    end else if (lu || md_struct) begin
      pc_keep     = 1'b1;
      ifid.keep   = 1'b1;
      idex.clear  = 1'b1;
    end else if (id_jump_i) begin
      ifid.clear  = 1'b1;
    end
  end

  assign pc_keep_o     = pc_keep;
  assign ifid_keep_o   = ifid.keep;
  assign ifid_clear_o  = ifid.clear;
  assign idex_keep_o   = idex.keep;
  assign idex_clear_o  = idex.clear;
  assign exmem_keep_o  = exmem.keep;
  assign exmem_clear_o = exmem.clear;
  assign memwb_keep_o  = memwb.keep;
  assign memwb_clear_o = memwb.clear;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                   cnt_d = '0;
    else if (pc_keep && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int MD  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_jump, id_md_start, id_md_read, ex_memread, br, mem_busy, cnt_clr;
  logic pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear;
  logic exmem_keep, exmem_clear, memwb_keep, memwb_clear, md_busy;
  logic [CW-1:0] stall_cnt;
  logic [8:0] ctrl;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt), .id_jump_i(id_jump),
    .id_md_start_i(id_md_start), .id_md_read_i(id_md_read),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .ex_branch_taken_i(br),
    .mem_busy_i(mem_busy), .cnt_clr_i(cnt_clr),
    .pc_keep_o(pc_keep), .ifid_keep_o(ifid_keep), .ifid_clear_o(ifid_clear),
    .idex_keep_o(idex_keep), .idex_clear_o(idex_clear),
    .exmem_keep_o(exmem_keep), .exmem_clear_o(exmem_clear),
    .memwb_keep_o(memwb_keep), .memwb_clear_o(memwb_clear),
    .md_busy_o(md_busy), .stall_cnt_o(stall_cnt)
  );

  assign ctrl = {pc_keep, ifid_keep, ifid_clear, idex_keep, idex_clear,
                 exmem_keep, exmem_clear, memwb_keep, memwb_clear};

  // Reference model: remaining busy cycles of the MD unit and a saturating stall tally.
  int   m_left;
  int   m_cnt;

  function automatic bit lu_f();
    return ex_memread && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit mds_f();
    return (m_left > 0) && (id_md_start || id_md_read);
  endfunction

  // {pc, ifid_k, ifid_c, idex_k, idex_c, exmem_k, exmem_c, memwb_k, memwb_c}
  function automatic logic [8:0] exp_ctrl();
    if (!rst)                    return 9'b0_00_00_00_00;
    if (mem_busy)                return 9'b1_10_10_10_01;
    if (br)                      return 9'b0_01_01_00_00;
    if (lu_f() || mds_f())       return 9'b1_10_01_00_00;
    if (id_jump)                 return 9'b0_01_00_00_00;
    return 9'b0;
  endfunction

  function automatic bit exp_stall();
    return rst && (mem_busy || (!br && (lu_f() || mds_f())));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_cnt  <= 0;
    end else begin
      if (m_left > 0) m_left <= m_left - 1;
      else if (id_md_start && !mem_busy && !br && !lu_f()) m_left <= MD;
      if (cnt_clr) m_cnt <= 0;
      else if (exp_stall()) m_cnt <= (m_cnt >= SAT) ? SAT : m_cnt + 1;
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_jump = 0;
    id_md_start = 0; id_md_read = 0; ex_memread = 0; br = 0; mem_busy = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    mem_busy = 1'b1;
    #12;
    if (ctrl !== 9'b0) begin $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 9'b0); fails++; end
    checks++;
    if (md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
      $display("FAIL reset_state busy=%b cnt=%0d exp busy=0 cnt=0", md_busy, stall_cnt); fails++;
    end
    checks++;
    idle();
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1; ex_rt = 8; id_rs = 8;
    #1;
    if (ctrl !== 9'b1_10_01_00_00) begin $display("FAIL lu_rs got=%b exp=%b", ctrl, 9'b1_10_01_00_00); fails++; end
    checks++;
    tick();
    ex_rt = 0; id_rs = 0;
    #1;
    if (ctrl !== 9'b0) begin $display("FAIL lu_r0 got=%b exp=%b", ctrl, 9'b0); fails++; end
    checks++;
    tick();
    ex_rt = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0;
    #1;
    if (ctrl !== 9'b0) begin $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, 9'b0); fails++; end
    checks++;
    id_uses_rt = 1; id_jump = 1;
    #1;
    if (ctrl !== 9'b1_10_01_00_00) begin $display("FAIL lu_rt_jump got=%b exp=%b", ctrl, 9'b1_10_01_00_00); fails++; end
    checks++;
    tick();
    idle();
  endtask

  task automatic test_branch_lu();
    idle();
    ex_memread = 1; ex_rt = 3; id_rs = 3; br = 1; id_jump = 1;
    #1;
    if (ctrl !== 9'b0_01_01_00_00) begin $display("FAIL branch_lu got=%b exp=%b", ctrl, 9'b0_01_01_00_00); fails++; end
    checks++;
    tick();
    idle();
    id_jump = 1;
    #1;
    if (ctrl !== 9'b0_01_00_00_00) begin $display("FAIL jump got=%b exp=%b", ctrl, 9'b0_01_00_00_00); fails++; end
    checks++;
    tick();
    idle();
  endtask

  task automatic test_md();
    int busy_n;
    idle();
    id_md_start = 1;
    #1;
    if (ctrl !== 9'b0 || md_busy !== 1'b0) begin
      $display("FAIL md_issue got ctrl=%b busy=%b exp ctrl=0 busy=0", ctrl, md_busy); fails++;
    end
    checks++;
    tick();
    id_md_start = 0; id_md_read = 1;
    busy_n = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (md_busy) busy_n++;
      if (md_busy !== (k <= MD) || pc_keep !== (k <= MD)) begin
        $display("FAIL md_mflo k=%0d busy=%b keep=%b exp=%b", k, md_busy, pc_keep, (k <= MD)); fails++;
      end
      checks++;
      tick();
    end
    if (busy_n != MD) begin $display("FAIL md_len got=%0d exp=%0d", busy_n, MD); fails++; end
    checks++;
    // back-to-back: second mult is held while the first is in flight
    id_md_read = 0; id_md_start = 1;
    tick();
    busy_n = 0;
    for (int k = 1; k <= MD + 2; k++) begin
      #1;
      if (md_busy) busy_n++;
      if (md_busy !== (m_left > 0) || ctrl !== exp_ctrl()) begin
        $display("FAIL md_b2b k=%0d busy=%b ctrl=%b exp busy=%b ctrl=%b", k, md_busy, ctrl, m_left > 0, exp_ctrl()); fails++;
      end
      checks++;
      tick();
    end
    if (busy_n != MD + 1) begin $display("FAIL md_reissue busy_cycles=%0d exp=%0d", busy_n, MD + 1); fails++; end
    checks++;
    idle();
    for (int k = 0; k < MD; k++) tick();
  endtask

  task automatic test_mem_busy_md();
    int busy_n;
    idle();
    mem_busy = 1; id_md_start = 1;
    tick();
    #1;
    if (md_busy !== 1'b0) begin $display("FAIL mem_blocks_issue busy=%b exp=0", md_busy); fails++; end
    checks++;
    mem_busy = 0;
    tick();
    id_md_start = 0;
    busy_n = 0;
    for (int k = 1; k <= MD + 1; k++) begin
      mem_busy = (k >= 2 && k <= 4);
      #1;
      if (md_busy) busy_n++;
      if (ctrl !== exp_ctrl() || (mem_busy && ctrl !== 9'b1_10_10_10_01)) begin
        $display("FAIL freeze k=%0d got=%b exp=%b", k, ctrl, exp_ctrl()); fails++;
      end
      checks++;
      tick();
    end
    if (busy_n != MD) begin $display("FAIL md_during_mem got=%0d exp=%0d", busy_n, MD); fails++; end
    checks++;
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    id_md_start = 1;
    tick();
    id_md_start = 0; ex_memread = 1; ex_rt = 2; id_rs = 2;
    tick();
    tick();
    mem_busy = 1;
    #2 rst = 1'b0;
    #1;
    if (md_busy !== 1'b0 || stall_cnt !== 4'd0 || ctrl !== 9'b0) begin
      $display("FAIL async_rst busy=%b cnt=%0d ctrl=%b exp all 0", md_busy, stall_cnt, ctrl); fails++;
    end
    checks++;
    idle();
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    idle();
    cnt_clr = 1;
    tick();
    cnt_clr = 0; ex_memread = 1; ex_rt = 9; id_rs = 9;
    for (int k = 0; k < 20; k++) tick();
    if (stall_cnt !== 4'd15 || int'(stall_cnt) != m_cnt) begin
      $display("FAIL cnt_sat got=%0d exp=15", stall_cnt); fails++;
    end
    checks++;
    cnt_clr = 1;
    tick();
    if (stall_cnt !== 4'd0) begin $display("FAIL cnt_clr got=%0d exp=0", stall_cnt); fails++; end
    checks++;
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      mem_busy    = ($urandom_range(5) == 0);
      br          = ($urandom_range(5) == 0);
      id_jump     = ($urandom_range(4) == 0);
      id_md_start = ($urandom_range(3) == 0);
      id_md_read  = ($urandom_range(4) == 0);
      ex_memread  = ($urandom_range(1) == 0);
      id_uses_rt  = ($urandom_range(1) == 0);
      ex_rt       = 5'($urandom_range(3));
      id_rs       = 5'($urandom_range(3));
      id_rt       = 5'($urandom_range(3));
      cnt_clr     = ($urandom_range(19) == 0);
      #1;
      if (ctrl !== exp_ctrl() || md_busy !== (m_left > 0) || int'(stall_cnt) != m_cnt) begin
        $display("FAIL rand k=%0d ctrl=%b busy=%b cnt=%0d exp ctrl=%b busy=%b cnt=%0d",
                 k, ctrl, md_busy, stall_cnt, exp_ctrl(), m_left > 0, m_cnt); fails++;
      end
      checks++;
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_md();
    test_mem_busy_md();
    test_async_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It generates the per-stage `keep_i`/`clear_i` controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC hold. It also tracks the multi-cycle multiply/divide unit and counts stall cycles. All stage controls are combinational from current inputs and registered state, so they take effect on the next `clk_i` edge of the pipeline registers they drive.

## Interface
Parameters:
- `MD_CYCLES`, 32, multiply/divide latency in cycles (≥2)
- `CNT_W`, 32, stall counter width

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset, asynchronous, active-low
- `id_rs_i` in 5: rs of instruction in ID
- `id_rt_i` in 5: rt of instruction in ID
- `id_uses_rt_i` in 1: ID instruction reads rt
- `id_jump_i` in 1: jump decoded in ID
- `id_md_start_i` in 1: mult/div in ID
- `id_md_read_i` in 1: mfhi/mflo in ID
- `ex_memread_i` in 1: load in EX
- `ex_rt_i` in 5: load destination in EX
- `ex_branch_taken_i` in 1: branch resolved taken in EX
- `mem_busy_i` in 1: data memory not ready
- `cnt_clr_i` in 1: synchronous clear of stall counter
- `pc_keep_o` out 1: hold PC
- `ifid_keep_o`, `ifid_clear_o` out 1 each
- `idex_keep_o`, `idex_clear_o` out 1 each
- `exmem_keep_o`, `exmem_clear_o` out 1 each
- `memwb_keep_o`, `memwb_clear_o` out 1 each
- `md_busy_o` out 1: MD unit busy
- `stall_cnt_o` out CNT_W: cycles with `pc_keep_o`=1

## Operation
Hazard conditions:
- `lu` (load-use): `ex_memread_i` && `ex_rt_i`≠0 && (`ex_rt_i`==`id_rs_i` || (`id_uses_rt_i` && `ex_rt_i`==`id_rt_i`)).
- `md_struct`: `md_busy_o` && (`id_md_start_i` || `id_md_read_i`).

Priority (highest first); any output not named is 0:
1. `mem_busy_i`: `pc_keep`, `ifid_keep`, `idex_keep` and `exmem_keep` are 1; `memwb_clear`=1.
2. `ex_branch_taken_i`: `ifid_clear`=1 and `idex_clear`=1. The ID instruction is squashed, so no `lu` or `md_struct` stall applies.
3. `lu` or `md_struct`: `pc_keep`=1, `ifid_keep`=1, `idex_clear`=1.
4. `id_jump_i`: `ifid_clear`=1.

`memwb_keep_o` and `exmem_clear_o` are tied 0. They exist only to fill out the interface.

MD FSM, states RUN and MD_BUSY:
- Issue condition: `id_md_start_i` && rows 1–3 all inactive. On an issue edge, the counter loads MD_CYCLES−1 and the state goes RUN→MD_BUSY.
- In MD_BUSY, the counter decrements every cycle, including during `mem_busy_i`. At counter==0 the state returns to RUN on the next edge.
- `md_busy_o` = (state==MD_BUSY). It is high for exactly MD_CYCLES cycles.
- An MD instruction in ID during the final busy cycle still stalls. It issues in the first RUN cycle.

Stall counter:
- Increments when `pc_keep_o`=1 and saturates at all-ones.
- `cnt_clr_i` forces 0 and takes priority over increment.

Reset (`rst_i`=0, async, any time including mid-MD or mid-stall):
- state=RUN, MD counter=0, `stall_cnt_o`=0, `md_busy_o`=0.
- All keep/clear outputs are forced to 0 while in reset.

## Timing
- Stage controls have zero latency: they are combinational and sampled by the pipeline registers on the same edge.
- `md_busy_o` rises 1 cycle after the issue edge and falls MD_CYCLES cycles later.
- `stall_cnt_o` reflects a stall cycle on the following edge.
- Simultaneous cases:
  - `mem_busy_i` with a branch: the branch is ignored that cycle. EX holds, so `ex_branch_taken_i` re-presents next cycle.
  - `mem_busy_i` with an MD issue: no issue.
  - `lu` with `id_jump_i`: the stall wins and the jump is re-evaluated next cycle.

## Structure
- Shared package `hazard_pkg`:
  - `md_state_t` {RUN, MD_BUSY}
  - `stage_ctrl_t` struct {keep, clear}
  - constant `REG_ZERO`=5'd0
- Sub-module `md_tracker`: FSM plus down-counter, with inputs `issue`, outputs `busy`.
- Top level holds the combinational priority logic and the stall counter.

## Test plan
- Load-use: `ex_memread_i`=1, `ex_rt_i`=8, `id_rs_i`=8 → `pc_keep`=`ifid_keep`=`idex_clear`=1 for one cycle. Same case with `ex_rt_i`=0 → no stall.
- Branch plus load-use together → `ifid_clear`=`idex_clear`=1, `pc_keep`=0.
- MD, MD_CYCLES=4: div issues at edge N. A mflo in ID from N+1 stalls 4 cycles, and `md_busy_o` is high cycles N+1..N+4. Issue of the following mult is blocked until RUN.
- `mem_busy_i` high 3 cycles during MD_BUSY → full freeze with `memwb_clear`=1. The MD counter still expires on schedule.
- `rst_i` pulsed low mid-MD_BUSY, unaligned to `clk_i` → `md_busy_o`=0 and `stall_cnt_o`=0 immediately.
- CNT_W=4: 20 stall cycles → counter saturates at 15. `cnt_clr_i` → 0.
